// File: rtl/cp_pkg.sv
// Shared types and helpers for the cyclic-prefix inserter.
// Optional per-beat index outputs are enabled with the CP_DOUT_INDEX_EN macro.
package cp_pkg;

   typedef enum logic [1:0] {
      R_IDLE = 2'd0,
      R_CP   = 2'd1,
      R_BODY = 2'd2
   } rd_state_t;

   // Default symbol length; the top derives its own length from NFFT_LOG2.
   localparam int NFFT = 64;

   // Prefix length for a symbol: long prefix on sel=0, short prefix on sel=1.
   function automatic int cp_len(input logic sel, input int cp_long, input int cp_short);
      return sel ? cp_short : cp_long;
   endfunction

endpackage

// File: rtl/cp_dpram.sv
// Simple dual-port RAM holding both ping-pong banks; address MSB selects the
// bank. Each word packs {real, imag}. One-cycle synchronous read.
module cp_dpram
   import cp_pkg::*;
#(
   parameter int AW = 7,
   parameter int DW = 36
) (
   input  logic          i_clk,
   input  logic          i_we,
   input  logic [AW-1:0] i_waddr,
   input  logic [DW-1:0] i_wdata,
   input  logic          i_re,
   input  logic [AW-1:0] i_raddr,
   output logic [DW-1:0] o_rdata
);

   logic [DW-1:0] r_mem [2**AW];

   // Write port: one sample per accepted input beat.
   always_ff @(posedge i_clk) begin
      if (i_we) r_mem[i_waddr] <= i_wdata;
   end

   // Read port: data appears the cycle after the address is issued.
   always_ff @(posedge i_clk) begin
      if (i_re) o_rdata <= r_mem[i_raddr];
   end

endmodule

// File: rtl/add_cyclic_prefix_pp.sv
// Cyclic-prefix inserter with a two-bank ping-pong buffer. Each NFFT-sample
// symbol is emitted as its last Ncp samples followed by the whole symbol.
// Define CP_DOUT_INDEX_EN to add dout_index/dout_sop/dout_eop outputs.
module add_cyclic_prefix_pp
   import cp_pkg::*;
#(
   parameter int DATAWIDTH = 18,
   parameter int NFFT_LOG2 = 6,
   parameter int CP_LONG   = 16,
   parameter int CP_SHORT  = 8
) (
   input  logic                 cp_clk,
   input  logic                 cp_rst,
   input  logic                 din_valid,
   output logic                 din_ready,
   input  logic                 din_sop,
   input  logic                 cp_sel,
   input  logic [DATAWIDTH-1:0] cp_real_din,
   input  logic [DATAWIDTH-1:0] cp_imag_din,
   output logic                 dout_valid,
   input  logic                 dout_ready,
   output logic [DATAWIDTH-1:0] cp_real_dout,
   output logic [DATAWIDTH-1:0] cp_imag_dout,
   output logic                 sym_err
`ifdef CP_DOUT_INDEX_EN
   ,
   output logic [NFFT_LOG2:0]   dout_index,
   output logic                 dout_sop,
   output logic                 dout_eop
`endif
);

   localparam int            AW   = NFFT_LOG2;
   localparam int            DW   = 2 * DATAWIDTH;
   localparam logic [AW-1:0] LAST = '1;
`ifdef CP_DOUT_INDEX_EN
   localparam int            XW   = AW + 3;
`else
   localparam int            XW   = 0;
`endif
   localparam int            SW   = DW + XW;

   // ---------------- write side ----------------
   logic          r_wr_bank;
   logic [AW-1:0] r_wr_cnt;
   logic [1:0]    r_full;
   logic [AW-1:0] r_ncp [2];
   logic          r_sel;
   logic          r_sym_err;

   logic          w_din_acc;
   logic [AW-1:0] w_wr_addr;
   logic          w_wr_last;
   logic          w_sel_eff;

   assign din_ready = ~r_full[r_wr_bank];
   assign w_din_acc = din_valid & din_ready;
   // A start-of-symbol always restarts the symbol at sample 0.
   assign w_wr_addr = din_sop ? '0 : r_wr_cnt;
   assign w_wr_last = (w_wr_addr == LAST);
   assign w_sel_eff = din_sop ? cp_sel : r_sel;
   assign sym_err   = r_sym_err;

   // ---------------- read side ----------------
   rd_state_t     r_state;
   logic          r_rd_bank;
   logic [AW-1:0] r_rd_addr;
   logic          r_pend;
   logic [SW-1:0] r_sk0;
   logic [SW-1:0] r_sk1;
   logic [1:0]    r_sk_cnt;

   logic          w_start;
   logic          w_active;
   logic          w_in_cp;
   logic [AW-1:0] w_ncp_cur;
   logic [AW-1:0] w_cp_base;
   logic [AW-1:0] w_rd_addr;
   logic          w_addr_last;
   logic          w_pop;
   logic [2:0]    w_occ;
   logic          w_issue;
   logic          w_rd_done;
   logic [DW-1:0] w_ram_q;
   logic [SW-1:0] w_new;

   // Leaving idle issues the first prefix read in the same cycle, which keeps
   // first-output latency at three cycles after the last input accept.
   assign w_start     = (r_state == R_IDLE) && r_full[r_rd_bank];
   assign w_active    = w_start || (r_state != R_IDLE);
   assign w_in_cp     = w_start || (r_state == R_CP);
   assign w_ncp_cur   = r_ncp[r_rd_bank];
   assign w_cp_base   = AW'(0) - w_ncp_cur;
   assign w_rd_addr   = w_start ? w_cp_base : r_rd_addr;
   assign w_addr_last = (w_rd_addr == LAST);
   assign w_pop       = (r_sk_cnt != 2'd0) && dout_ready;
   // Occupancy after this cycle's push/pop; a new read is only issued if its
   // data will find a free skid slot next cycle.
   assign w_occ       = 3'(r_sk_cnt) + 3'(r_pend) - 3'(w_pop);
   assign w_issue     = w_active && (w_occ < 3'd2);
   assign w_rd_done   = w_issue && !w_in_cp && w_addr_last;

   // Write counter, bank toggle, per-bank prefix length and sticky framing error.
   always_ff @(posedge cp_clk or posedge cp_rst) begin
      if (cp_rst) begin
         r_wr_bank <= 1'b0;
         r_wr_cnt  <= '0;
         r_ncp[0]  <= '0;
         r_ncp[1]  <= '0;
         r_sel     <= 1'b0;
         r_sym_err <= 1'b0;
      end else if (w_din_acc) begin
         if (din_sop) r_sel <= cp_sel;
         if ((din_sop && (r_wr_cnt != '0)) || (!din_sop && (r_wr_cnt == '0)))
            r_sym_err <= 1'b1;
         if (w_wr_last) begin
            r_wr_cnt         <= '0;
            r_wr_bank        <= ~r_wr_bank;
            r_ncp[r_wr_bank] <= AW'(cp_len(w_sel_eff, CP_LONG, CP_SHORT));
         end else begin
            r_wr_cnt <= w_wr_addr + 1'b1;
         end
      end
   end

   // Bank full flags: set by the writer on the last sample, cleared by the
   // reader on the last body read. They never target the same bank at once.
   always_ff @(posedge cp_clk or posedge cp_rst) begin
      if (cp_rst) begin
         r_full <= 2'b00;
      end else begin
         if (w_din_acc && w_wr_last) r_full[r_wr_bank] <= 1'b1;
         if (w_rd_done)              r_full[r_rd_bank] <= 1'b0;
      end
   end

   // Read FSM: prefix addresses, then the full body, then the next bank.
   always_ff @(posedge cp_clk or posedge cp_rst) begin
      if (cp_rst) begin
         r_state   <= R_IDLE;
         r_rd_bank <= 1'b0;
         r_rd_addr <= '0;
      end else if (w_issue) begin
         if (w_in_cp) begin
            if (w_addr_last) begin
               r_state   <= R_BODY;
               r_rd_addr <= '0;
            end else begin
               r_state   <= R_CP;
               r_rd_addr <= w_rd_addr + 1'b1;
            end
         end else if (w_addr_last) begin
            r_rd_bank <= ~r_rd_bank;
            if (r_full[~r_rd_bank]) begin
               r_state   <= R_CP;
               r_rd_addr <= AW'(0) - r_ncp[~r_rd_bank];
            end else begin
               r_state   <= R_IDLE;
               r_rd_addr <= '0;
            end
         end else begin
            r_rd_addr <= w_rd_addr + 1'b1;
         end
      end
   end

   cp_dpram #(
      .AW (AW + 1),
      .DW (DW)
   ) u_ram (
      .i_clk   (cp_clk),
      .i_we    (w_din_acc),
      .i_waddr ({r_wr_bank, w_wr_addr}),
      .i_wdata ({cp_real_din, cp_imag_din}),
      .i_re    (w_issue),
      .i_raddr ({r_rd_bank, w_rd_addr}),
      .o_rdata (w_ram_q)
   );

`ifdef CP_DOUT_INDEX_EN
   logic [AW:0]   w_idx;
   logic [XW-1:0] r_pend_x;

   assign w_idx = w_in_cp ? (AW+1)'(w_rd_addr - w_cp_base)
                          : ({1'b0, w_rd_addr} + {1'b0, w_ncp_cur});

   // Index/sop/eop travel one cycle alongside the RAM read.
   always_ff @(posedge cp_clk or posedge cp_rst) begin
      if (cp_rst) r_pend_x <= '0;
      else        r_pend_x <= {w_idx, (w_idx == '0), (!w_in_cp && w_addr_last)};
   end

   assign w_new      = {r_pend_x, w_ram_q};
   assign dout_index = r_sk0[SW-1 -: (AW+1)];
   assign dout_sop   = r_sk0[DW+1];
   assign dout_eop   = r_sk0[DW];
`else
   assign w_new = w_ram_q;
`endif

   // Two-entry output skid; entry 0 drives the outputs and holds while stalled.
   always_ff @(posedge cp_clk or posedge cp_rst) begin
      if (cp_rst) begin
         r_pend   <= 1'b0;
         r_sk0    <= '0;
         r_sk1    <= '0;
         r_sk_cnt <= 2'd0;
      end else begin
         r_pend <= w_issue;
         case ({r_pend, w_pop})
            2'b01: begin
               r_sk0    <= r_sk1;
               r_sk_cnt <= r_sk_cnt - 2'd1;
            end
            2'b10: begin
               if (r_sk_cnt == 2'd0) r_sk0 <= w_new;
               else                  r_sk1 <= w_new;
               r_sk_cnt <= r_sk_cnt + 2'd1;
            end
            2'b11: begin
               if (r_sk_cnt == 2'd1) begin
                  r_sk0 <= w_new;
               end else begin
                  r_sk0 <= r_sk1;
                  r_sk1 <= w_new;
               end
            end
            default: ;
         endcase
      end
   end

   assign dout_valid   = (r_sk_cnt != 2'd0);
   assign cp_real_dout = r_sk0[DW-1:DATAWIDTH];
   assign cp_imag_dout = r_sk0[DATAWIDTH-1:0];

endmodule
